ascon_result_collector: RTL
===========================

ASCON_RESULT_COLLECTOR -- requirements
Module: ascon_result_collector

Interface
REQ-001 Parameter Y, default 104, the payload bit length (output_dataxSI stream length), 1..128.
REQ-002 Parameter T, default 128, the tag bit length; fixed at 128.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ascon_readyxSI  input  1  upstream core-done flag; stays high while serial results shift out.
REQ-006 output_dataxSI  input  1  serial payload; bit n is valid the cycle after the n-th cycle with ascon_readyxSI high, LSB first.
REQ-007 tagxSI  input  1  serial tag; same timing as output_dataxSI, LSB first.
REQ-008 decrypt_i  input  1  operation mode, sampled at capture start (1 = decryption).
REQ-009 expected_tag_i  input  128  reference tag for decryption, sampled when capture completes.
REQ-010 result_ready_i  input  1  consumer accepts the result.
REQ-011 result_valid_o  output  1  result held and stable.
REQ-012 data_o  output  Y  deserialised payload, data_o[n] = payload bit n.
REQ-013 tag_o  output  128  deserialised tag, tag_o[n] = tag bit n.
REQ-014 tag_match_o  output  1  authentication status, valid with result_valid_o.
REQ-015 busy_o  output  1  high in every state except IDLE.

Function
REQ-016 The block SHALL have four states: IDLE, CAPTURE, DONE, DRAIN.
REQ-017 The block SHALL register rdy_d, a one-cycle delayed copy of ascon_readyxSI, every cycle.
REQ-018 In IDLE, when ascon_readyxSI=1, the block SHALL enter CAPTURE, clear the 8-bit bit counter cnt to 0, and latch decrypt_i into mode.
REQ-019 In CAPTURE, on each cycle with rdy_d=1, the block SHALL write output_dataxSI to data_o[cnt] when cnt<Y, write tagxSI to tag_o[cnt], and increment cnt.
REQ-020 In CAPTURE, on cycles with rdy_d=0, the block SHALL hold cnt and all captured bits (stall).
REQ-021 When the bit at cnt=127 is captured, the block SHALL enter DONE on the next edge with result_valid_o=1; total capture spans 128 rdy_d-high cycles regardless of Y.
REQ-022 On the DONE-entry edge, the block SHALL compute tag_match_o = 1 if mode=0, else (captured tag == expected_tag_i).
REQ-023 If mode=1 and the tag mismatches, the block SHALL present data_o as all zeros; the unverified plaintext is never released.
REQ-024 In DONE, data_o, tag_o and tag_match_o SHALL stay stable until result_valid_o & result_ready_i.
REQ-025 On handshake, the block SHALL drop result_valid_o on the next edge and enter DRAIN.
REQ-026 In DRAIN, the block SHALL return to IDLE on the first cycle with ascon_readyxSI=0; it ignores the serial inputs in DRAIN.
REQ-027 Once any result has been handshaken, data_o, tag_o and tag_match_o SHALL keep their last values until the next capture overwrites them.
REQ-028 result_ready_i asserted outside DONE SHALL have no effect.
REQ-029 result_valid_o SHALL be high only in DONE.

Reset
REQ-030 With rst=1, the block SHALL set the state to IDLE and clear rdy_d, cnt, mode, data_o, tag_o, tag_match_o, result_valid_o and busy_o to 0 on the next edge.
REQ-031 rst SHALL take priority over all other inputs, including mid-CAPTURE, and no partial result SHALL become valid.

Verification
REQ-032 Encrypt: decrypt_i=0, ascon_readyxSI rises and stays high, payload 0x0123456789ABCDEF0011223344, tag 0xFEDC...10 shifted LSB first -> result_valid_o rises 129 cycles after ready rises, data_o and tag_o equal the shifted values, tag_match_o=1.
REQ-033 Decrypt match: decrypt_i=1, expected_tag_i equals the streamed tag -> tag_match_o=1 and data_o equals the streamed payload.
REQ-034 Decrypt mismatch: expected_tag_i differs in bit 0 -> tag_match_o=0 and data_o=0; tag_o still equals the streamed tag.
REQ-035 Backpressure: result_ready_i=0 for 10 cycles after valid -> outputs are stable for all 10 cycles; a 1-cycle ready gives exactly one handshake; the block stays in DRAIN until ascon_readyxSI=0, then busy_o=0.
REQ-036 Stall: ascon_readyxSI dropped for 3 cycles mid-stream (cnt=50), then restored -> capture resumes at bit 50 and the result is correct.
REQ-037 Reset at cnt=64 -> all outputs are 0 on the next edge and result_valid_o never asserts; a following full capture is correct.

Source files
------------

// File: rtl/ascon_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_result_collector
//  Description : Deserialises the Ascon core's serial payload and tag streams,
//                checks the tag against a reference when decrypting, and holds
//                the result behind a valid/ready handshake. Plaintext whose
//                tag fails to verify is replaced by zeros before release.
//  Revision    : 1.0 - initial release
// ============================================================================
module ascon_result_collector #(
    parameter int Y = 104,
    parameter int T = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ascon_readyxSI,
    input  logic         output_dataxSI,
    input  logic         tagxSI,
    input  logic         decrypt_i,
    input  logic [127:0] expected_tag_i,
    input  logic         result_ready_i,
    output logic         result_valid_o,
    output logic [Y-1:0] data_o,
    output logic [T-1:0] tag_o,
    output logic         tag_match_o,
    output logic         busy_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    // Index of the final serial bit; the stream always spans the full tag
    // length, even when the payload is shorter.
    localparam logic [7:0] LAST_BIT = 8'(T - 1);

    logic [1:0]   state;
    logic [1:0]   next_state;
    logic         rdy_d;
    logic [7:0]   cnt;
    logic         mode;
    logic         capture_en;
    logic         last_bit;
    logic         start;
    logic [T-1:0] tag_next;
    logic         tag_ok;

    // A serial bit is present on the cycle after each ready-high cycle, so
    // captures are qualified by the delayed ready rather than the live one.
    assign capture_en = (state == S_CAPTURE) && rdy_d;
    assign last_bit   = capture_en && (cnt == LAST_BIT);
    assign start      = (state == S_IDLE) && ascon_readyxSI;

    // Tag value including the bit arriving this cycle, so the comparison on
    // the final edge sees the complete tag.
    assign tag_next   = {tagxSI, tag_o[T-1:1]};
    assign tag_ok     = (tag_next == expected_tag_i);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (ascon_readyxSI) begin
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (last_bit) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ready_i) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Wait for the core to release its done flag so the same
                // result is not captured twice.
                if (!ascon_readyxSI) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        result_valid_o = 1'b0;
        busy_o         = 1'b1;
        case (state)
            S_IDLE:  busy_o         = 1'b0;
            S_DONE:  result_valid_o = 1'b1;
            default: begin
                result_valid_o = 1'b0;
                busy_o         = 1'b1;
            end
        endcase
    end

    // Delayed ready flag, tracked unconditionally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_d <= 1'b0;
        end else begin
            rdy_d <= ascon_readyxSI;
        end
    end

    // Bit counter and operation mode, both armed when a new result starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 8'd0;
            mode <= 1'b0;
        end else if (start) begin
            cnt  <= 8'd0;
            mode <= decrypt_i;
        end else if (capture_en) begin
            cnt  <= cnt + 8'd1;
        end
    end

    // Tag deserialiser: LSB arrives first, so shifting in from the top leaves
    // bit n at position n after the full stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_o <= '0;
        end else if (capture_en) begin
            tag_o <= tag_next;
        end
    end

    // Payload deserialiser: only the first Y bits of the stream are kept. A
    // failed decryption overwrites the payload with zeros on the final edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o <= '0;
        end else if (capture_en) begin
            for (int i = 0; i < Y; i++) begin
                if (cnt == 8'(i)) begin
                    data_o[i] <= output_dataxSI;
                end
            end
            if (last_bit && mode && !tag_ok) begin
                data_o <= '0;
            end
        end
    end

    // Authentication status, decided once on the final capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_match_o <= 1'b0;
        end else if (last_bit) begin
            tag_match_o <= mode ? tag_ok : 1'b1;
        end
    end

endmodule
`default_nettype wire
